// File: rtl/sprite_store_match.sv
// Per-line sprite store with X-match lookup and a two-state fetch requester.
// Optional sticky store-full flag is enabled by defining SPRITE_STORE_OVERFLOW_EN.
module sprite_store_match #(
    parameter int SLOTS = 10,
    parameter int XW    = 8
) (
    input  logic          clk1,
    input  logic          reset_video,
    input  logic          line_start,
    input  logic          wr_en,
    input  logic [XW-1:0] wr_x,
    input  logic [5:0]    wr_idx,
    input  logic [3:0]    wr_line,
    input  logic          render_en,
    input  logic [XW-1:0] pix_x,
    output logic          fetch_req,
    output logic [5:0]    fetch_idx,
    output logic [3:0]    fetch_line,
    input  logic          fetch_ack,
    output logic          stall,
    output logic [3:0]    count,
    output logic          overflow
);

    // Handshake: fetch_req rises the cycle after a match and holds fetch_idx and
    // fetch_line stable until a one-cycle fetch_ack (or an abort) is seen.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SLOTS-1:0]  valid_q, valid_d;
    logic [XW-1:0]     x_q    [SLOTS];
    logic [5:0]        idx_q  [SLOTS];
    logic [3:0]        line_q [SLOTS];
    logic [3:0]        count_q, count_d;
    logic [3:0]        sel_q, sel_d;
    logic [5:0]        fetch_idx_q, fetch_idx_d;
    logic [3:0]        fetch_line_q, fetch_line_d;

    logic [SLOTS-1:0]  match;
    logic              any_match;
    logic [3:0]        sel_c;
    logic [5:0]        match_idx;
    logic [3:0]        match_line;
    logic              store_full;
    logic              wr_accept;
    logic              ack_clear;

    assign store_full = (count_q == 4'(SLOTS));
    assign wr_accept  = wr_en && !line_start && !store_full;

    // Lowest matching slot wins: scan downwards so the smallest index is last written.
    always_comb begin
        match      = '0;
        sel_c      = '0;
        match_idx  = '0;
        match_line = '0;
        for (int i = 0; i < SLOTS; i++) begin
            match[i] = valid_q[i] && render_en && (x_q[i] == pix_x);
        end
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel_c      = 4'(i);
                match_idx  = idx_q[i];
                match_line = line_q[i];
            end
        end
    end

    assign any_match = |match;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        fetch_idx_d  = fetch_idx_q;
        fetch_line_d = fetch_line_q;
        ack_clear    = 1'b0;
        if (line_start) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_match) begin
                        state_d      = S_REQ;
                        sel_d        = sel_c;
                        fetch_idx_d  = match_idx;
                        fetch_line_d = match_line;
                    end
                end
                S_REQ: begin
                    // Abort keeps the slot valid so the same sprite is requested again.
                    if (!render_en) begin
                        state_d = S_IDLE;
                    end else if (fetch_ack) begin
                        state_d   = S_IDLE;
                        ack_clear = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (line_start) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (ack_clear && (sel_q == 4'(i))) valid_d[i] = 1'b0;
                if (wr_accept && (count_q == 4'(i))) valid_d[i] = 1'b1;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (line_start) begin
            count_d = '0;
        end else if (wr_accept) begin
            count_d = count_q + 4'd1;
        end
    end

    always_ff @(posedge clk1 or posedge reset_video) begin
        if (reset_video) begin
            state_q      <= S_IDLE;
            valid_q      <= '0;
            count_q      <= '0;
            sel_q        <= '0;
            fetch_idx_q  <= '0;
            fetch_line_q <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            count_q      <= count_d;
            sel_q        <= sel_d;
            fetch_idx_q  <= fetch_idx_d;
            fetch_line_q <= fetch_line_d;
        end
    end

    always_ff @(posedge clk1 or posedge reset_video) begin
        if (reset_video) begin
            for (int i = 0; i < SLOTS; i++) begin
                x_q[i]    <= '0;
                idx_q[i]  <= '0;
                line_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_accept && (count_q == 4'(i))) begin
                    x_q[i]    <= wr_x;
                    idx_q[i]  <= wr_idx;
                    line_q[i] <= wr_line;
                end
            end
        end
    end

`ifdef SPRITE_STORE_OVERFLOW_EN
    logic overflow_q;

    always_ff @(posedge clk1 or posedge reset_video) begin
        if (reset_video) begin
            overflow_q <= 1'b0;
        end else if (line_start) begin
            overflow_q <= 1'b0;
        end else if (wr_en && store_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    assign fetch_req  = (state_q == S_REQ);
    assign fetch_idx  = fetch_idx_q;
    assign fetch_line = fetch_line_q;
    assign count      = count_q;
    assign stall      = any_match || (state_q == S_REQ);

endmodule

// File: tb/tb_sprite_store_match.sv
// Directed bench for sprite_store_match: fetch requests are scoreboarded
// against an expected queue of {idx, line} pushed when stimulus is driven.
module tb_sprite_store_match;

    logic       clk1;
    logic       reset_video;
    logic       line_start;
    logic       wr_en;
    logic [7:0] wr_x;
    logic [5:0] wr_idx;
    logic [3:0] wr_line;
    logic       render_en;
    logic [7:0] pix_x;
    logic       fetch_req;
    logic [5:0] fetch_idx;
    logic [3:0] fetch_line;
    logic       fetch_ack;
    logic       stall;
    logic [3:0] count;
    logic       overflow;

    int tests  = 0;
    int failed = 0;
    logic [9:0] exp_q[$];
    logic       exp_ovf;

    sprite_store_match #(.SLOTS(10), .XW(8)) dut (
        .clk1(clk1),
        .reset_video(reset_video),
        .line_start(line_start),
        .wr_en(wr_en),
        .wr_x(wr_x),
        .wr_idx(wr_idx),
        .wr_line(wr_line),
        .render_en(render_en),
        .pix_x(pix_x),
        .fetch_req(fetch_req),
        .fetch_idx(fetch_idx),
        .fetch_line(fetch_line),
        .fetch_ack(fetch_ack),
        .stall(stall),
        .count(count),
        .overflow(overflow)
    );

    // clock
    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] x, input logic [5:0] idx, input logic [3:0] line);
        wr_en   = 1'b1;
        wr_x    = x;
        wr_idx  = idx;
        wr_line = line;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic new_line();
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    // Pop the scoreboard and compare against the request currently on the bus.
    task automatic check_req(input string tag);
        logic [9:0] e;
        chk({tag, "_req"}, 32'(fetch_req), 32'd1);
        tests++;
        assert (exp_q.size() != 0) else begin
            failed++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_idx"}, 32'(fetch_idx), 32'(e[9:4]));
            chk({tag, "_line"}, 32'(fetch_line), 32'(e[3:0]));
        end
    endtask

    initial begin
`ifdef SPRITE_STORE_OVERFLOW_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        reset_video = 1'b1;
        line_start  = 1'b0;
        wr_en       = 1'b0;
        wr_x        = '0;
        wr_idx      = '0;
        wr_line     = '0;
        render_en   = 1'b0;
        pix_x       = '0;
        fetch_ack   = 1'b0;
        #2;
        chk("rst_req", 32'(fetch_req), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_idx", 32'(fetch_idx), 0);
        chk("rst_line", 32'(fetch_line), 0);
        chk("rst_ovf", 32'(overflow), 0);
        #1 reset_video = 1'b0;
        tick();

        // three entries, two sharing x=8
        wr(8'd8, 6'd5, 4'd2);
        wr(8'd20, 6'd9, 4'd3);
        wr(8'd8, 6'd1, 4'd4);
        chk("wr3_count", 32'(count), 3);

        // ack with nothing pending is ignored
        render_en = 1'b1;
        pix_x     = 8'd50;
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        #1;
        chk("idle_ack_req", 32'(fetch_req), 0);
        chk("idle_ack_stall", 32'(stall), 0);
        chk("idle_ack_count", 32'(count), 3);

        pix_x = 8'd8;
        exp_q.push_back({6'd5, 4'd2});
        #1;
        chk("m8_stall_comb", 32'(stall), 1);
        chk("m8_req_early", 32'(fetch_req), 0);
        tick();
        check_req("m8_first");
        tick();
        chk("m8_hold_idx", 32'(fetch_idx), 5);
        chk("m8_hold_req", 32'(fetch_req), 1);
        fetch_ack = 1'b1;
        exp_q.push_back({6'd1, 4'd4});
        tick();
        fetch_ack = 1'b0;
        #1;
        chk("m8_gap_req", 32'(fetch_req), 0);
        chk("m8_gap_stall", 32'(stall), 1);
        tick();
        check_req("m8_second");
        chk("m8_second_stall", 32'(stall), 1);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        #1;
        chk("m8_done_req", 32'(fetch_req), 0);
        chk("m8_done_stall", 32'(stall), 0);
        chk("m8_done_count", 32'(count), 3);

        pix_x = 8'd20;
        exp_q.push_back({6'd9, 4'd3});
        #1;
        chk("m20_stall", 32'(stall), 1);
        tick();
        check_req("m20");
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        render_en = 1'b0;

        // render abort keeps the slot for a retry
        new_line();
        wr(8'd30, 6'd7, 4'd6);
        render_en = 1'b1;
        pix_x     = 8'd30;
        exp_q.push_back({6'd7, 4'd6});
        tick();
        check_req("abort_a");
        render_en = 1'b0;
        #1;
        chk("abort_stall_req", 32'(stall), 1);
        tick();
        chk("abort_req", 32'(fetch_req), 0);
        chk("abort_stall", 32'(stall), 0);
        render_en = 1'b1;
        exp_q.push_back({6'd7, 4'd6});
        #1;
        chk("retry_stall", 32'(stall), 1);
        tick();
        check_req("retry");

        // line_start beats a simultaneous write while requesting
        line_start = 1'b1;
        wr_en      = 1'b1;
        wr_x       = 8'd30;
        wr_idx     = 6'd8;
        wr_line    = 4'd0;
        tick();
        line_start = 1'b0;
        wr_en      = 1'b0;
        #1;
        chk("ls_count", 32'(count), 0);
        chk("ls_req", 32'(fetch_req), 0);
        chk("ls_stall", 32'(stall), 0);
        tick();
        chk("ls_nostore", 32'(fetch_req), 0);
        render_en = 1'b0;

        // fill past capacity
        for (int i = 0; i < 11; i++) begin
            wr(8'(100 + i), 6'(i), 4'(i));
            if (i == 9) begin
                chk("full_count", 32'(count), 10);
                chk("full_ovf", 32'(overflow), 0);
            end
        end
        chk("over_count", 32'(count), 10);
        chk("over_ovf", 32'(overflow), 32'(exp_ovf));
        render_en = 1'b1;
        pix_x     = 8'd110;
        #1;
        chk("over_ignored", 32'(stall), 0);
        pix_x = 8'd109;
        #1;
        chk("over_last_kept", 32'(stall), 1);
        render_en = 1'b0;
        new_line();
        chk("clr_count", 32'(count), 0);
        chk("clr_ovf", 32'(overflow), 0);

        // write and ack-clear to different slots in one cycle
        wr(8'd40, 6'd3, 4'd1);
        render_en = 1'b1;
        pix_x     = 8'd40;
        exp_q.push_back({6'd3, 4'd1});
        tick();
        check_req("same_a");
        fetch_ack = 1'b1;
        wr_en     = 1'b1;
        wr_x      = 8'd40;
        wr_idx    = 6'd11;
        wr_line   = 4'd2;
        exp_q.push_back({6'd11, 4'd2});
        tick();
        fetch_ack = 1'b0;
        wr_en     = 1'b0;
        chk("same_count", 32'(count), 2);
        chk("same_req_gap", 32'(fetch_req), 0);
        tick();
        check_req("same_b");
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        render_en = 1'b0;

        // asynchronous reset in the middle of a request
        new_line();
        wr(8'd60, 6'd13, 4'd5);
        render_en = 1'b1;
        pix_x     = 8'd60;
        exp_q.push_back({6'd13, 4'd5});
        tick();
        check_req("pre_rst");
        #2 reset_video = 1'b1;
        #1;
        chk("arst_req", 32'(fetch_req), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_stall", 32'(stall), 0);
        chk("arst_idx", 32'(fetch_idx), 0);
        chk("arst_line", 32'(fetch_line), 0);
        reset_video = 1'b0;
        tick();
        chk("post_rst_req", 32'(fetch_req), 0);
        wr(8'd60, 6'd2, 4'd1);
        chk("resume_count", 32'(count), 1);
        chk("resume_stall", 32'(stall), 1);
        exp_q.push_back({6'd2, 4'd1});
        tick();
        check_req("resume");
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        render_en = 1'b0;
        tick();

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sprite_store_match.md
SPRITE_STORE_MATCH -- requirements
Module: sprite_store_match

Interface
REQ-001 Parameter SLOTS, default 10: number of sprite store slots, range 1..15.
REQ-002 Parameter XW, default 8: width of sprite X and pixel X values.
REQ-003 Port clk1  in  1: sole clock, rising-edge active.
REQ-004 Port reset_video  in  1: asynchronous, active-high reset.
REQ-005 Port line_start  in  1: synchronous per-line clear of all slots.
REQ-006 Port wr_en  in  1: scanner store-write strobe.
REQ-007 Port wr_x  in  XW: sprite X of the written entry.
REQ-008 Port wr_idx  in  6: OAM index of the written entry.
REQ-009 Port wr_line  in  4: sprite row of the written entry.
REQ-010 Port render_en  in  1: pixel rendering active.
REQ-011 Port pix_x  in  XW: current pixel X counter.
REQ-012 Port fetch_req  out  1: sprite fetch request to the fetcher.
REQ-013 Port fetch_idx  out  6: OAM index of the requested sprite.
REQ-014 Port fetch_line  out  4: row of the requested sprite.
REQ-015 Port fetch_ack  in  1: fetcher completion, one-cycle pulse.
REQ-016 Port stall  out  1: pixel pipe hold.
REQ-017 Port count  out  4: number of entries stored this line.
REQ-018 Port overflow  out  1: sticky store-full write flag (see Configuration).

Function
REQ-019 On wr_en with count<SLOTS, slot[count] SHALL load {valid=1, wr_x, wr_idx, wr_line} and count SHALL increment, both visible the next cycle.
REQ-020 On wr_en with count==SLOTS, the write SHALL be ignored and count SHALL hold.
REQ-021 On line_start, all valid bits and count SHALL clear the next cycle, FSM SHALL return to IDLE, and a same-cycle wr_en SHALL be discarded.
REQ-022 Slot i SHALL match combinationally when valid[i] && render_en && x[i]==pix_x; sel = lowest matching index.
REQ-023 FSM states: IDLE, REQ.
REQ-024 IDLE: with any match present, latch sel, idx[sel] and line[sel] and enter REQ; fetch_req=1 from the next cycle.
REQ-025 REQ: fetch_req, fetch_idx and fetch_line SHALL hold stable until fetch_ack.
REQ-026 On fetch_ack in REQ: valid[sel] clears, fetch_req drops, and the state returns to IDLE, all visible the next cycle.
REQ-027 fetch_ack in IDLE SHALL be ignored.
REQ-028 render_en low in REQ: abort to IDLE, fetch_req drops next cycle, valid[sel] is retained.
REQ-029 stall SHALL be combinational: (any match) || (state==REQ).
REQ-030 Latency: match at cycle N -> fetch_req at N+1; ack at M -> the next request for the same pix_x at M+2 at the earliest.
REQ-031 Multiple slots with equal X SHALL be served one at a time in ascending slot order, with stall held throughout.
REQ-032 count SHALL NOT decrement when a slot is consumed.
REQ-033 A write and a fetch-clear to different slots in the same cycle SHALL both take effect.

Reset
REQ-034 reset_video high SHALL immediately force state=IDLE, all valid bits=0, count=0, fetch_req=0, fetch_idx=0, fetch_line=0, overflow=0; stall=0 follows.
REQ-035 After reset_video deasserts, operation SHALL resume on the first clk1 rising edge.

Configuration
REQ-036 Macro SPRITE_STORE_OVERFLOW_EN defined: overflow sets on wr_en with count==SLOTS, is sticky, and clears on line_start or reset.
REQ-037 Macro SPRITE_STORE_OVERFLOW_EN undefined: overflow SHALL be tied to 0 and carry no register.

Verification
REQ-038 Write 3 entries (x=8,idx=5,line=2),(x=20,idx=9),(x=8,idx=1); render, pix_x=8 -> req idx=5; ack -> req idx=1; both stalled; pix_x=20 -> idx=9.
REQ-039 Write 11 entries with SLOTS=10 -> count=10, 11th ignored, overflow=1 (macro on) / 0 (macro off); line_start -> count=0, overflow=0.
REQ-040 Drop render_en while fetch_req=1 (idx=7) -> fetch_req=0 next cycle; re-enable at the same pix_x -> idx=7 requested again.
REQ-041 line_start together with wr_en in REQ -> next cycle count=0, fetch_req=0, no entry stored.
REQ-042 Assert reset_video mid-REQ between clock edges -> fetch_req, count and stall go 0 without a clock edge.
REQ-043 fetch_ack pulses in IDLE with no match -> no state change, valid bits unchanged.
